// File: rtl/core_logic_pkg.sv
`default_nettype none
// ============================================================================
// Module  : core_logic_pkg
// Purpose : Shared types and the per-pair operation function for the
//           pipelined JTAG core-logic block.
//           op_e    - 2-bit operation code
//           stage_t - one pipeline stage of a pair: {op, b, a}
//           core_op - evaluates one op on one operand pair -> {hi, lo}
// Revision: 1.0 - initial release
// ============================================================================
package core_logic_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_ANDOR = 2'd0,
      OP_XOR   = 2'd1,
      OP_NAND  = 2'd2,
      OP_HADD  = 2'd3
   } op_e;

   typedef struct packed {
      op_e  op;
      logic b;
      logic a;
   } stage_t;

   // Result is {hi, lo}; lo lands on the even output bit of the pair.
   function automatic logic [OP_W-1:0] core_op(input op_e op, input logic a, input logic b);
      logic [OP_W-1:0] res;
      res = '0;
      case (op)
         OP_ANDOR: res = {a | b, a & b};
         OP_XOR:   res = {~(a ^ b), a ^ b};
         OP_NAND:  res = {~(a | b), ~(a & b)};
         OP_HADD:  res = {a & b, a ^ b};
      endcase
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/core_logic_pair.sv
`default_nettype none
// ============================================================================
// Module  : core_logic_pair
// Purpose : One operand pair: runtime mode register, operand/mode pipeline of
//           LATENCY-1 stages, and a result register loaded when out_en is set.
// Ports   : TCK, TRST_N       - clock, async active-low reset
//           mode_load_i       - load mode_i into the mode register
//           mode_i [1:0]      - op code for this pair
//           a, b              - operands
//           out_en            - result register load (capture reaching output)
//           result [1:0]      - {hi, lo}
// Revision: 1.0 - initial release
// ============================================================================
module core_logic_pair
   import core_logic_pkg::*;
#(
   parameter int LATENCY = 1
) (
   input  logic            TCK,
   input  logic            TRST_N,
   input  logic            mode_load_i,
   input  logic [OP_W-1:0] mode_i,
   input  logic            a,
   input  logic            b,
   input  logic            out_en,
   output logic [OP_W-1:0] result
);

   op_e             r_mode;
   stage_t          w_last;
   logic [OP_W-1:0] r_result;

   // A capture in the same cycle as a load still sees the old mode.
   always_ff @(posedge TCK or negedge TRST_N) begin
      if (!TRST_N)          r_mode <= OP_ANDOR;
      else if (mode_load_i) r_mode <= op_e'(mode_i);
   end

   if (LATENCY == 1) begin : g_direct
      assign w_last = '{op: r_mode, b: b, a: a};
   end else begin : g_stages
      // Mode travels with its operands so later loads never touch in-flight data.
      stage_t r_stage [LATENCY-1];
      always_ff @(posedge TCK or negedge TRST_N) begin
         if (!TRST_N) begin
            for (int i = 0; i < LATENCY-1; i++) r_stage[i] <= '0;
         end else begin
            r_stage[0] <= '{op: r_mode, b: b, a: a};
            for (int i = 1; i < LATENCY-1; i++) r_stage[i] <= r_stage[i-1];
         end
      end
      assign w_last = r_stage[LATENCY-2];
   end

   always_ff @(posedge TCK or negedge TRST_N) begin
      if (!TRST_N)     r_result <= '0;
      else if (out_en) r_result <= core_op(w_last.op, w_last.a, w_last.b);
   end

   assign result = r_result;

endmodule
`default_nettype wire

// File: rtl/core_logic_pipe.sv
`default_nettype none
// ============================================================================
// Module  : core_logic_pipe
// Purpose : Registered, parametrised JTAG core-logic block. NUM_PAIRS operand
//           pairs with per-pair runtime op, LATENCY-deep pipeline on TCK,
//           valid strobe for the BSR capture side, optional output MISR.
// Config  : CORE_LOGIC_MISR_EN - when defined, builds the MISR over data_out;
//           otherwise misr_o is tied to zero and misr_clr_i is ignored.
// Ports   : TCK, TRST_N            - clock, async active-low reset
//           capture_i              - sample data_in and current modes
//           data_in  [2*NP-1:0]    - pair k = {b,a} at [2k+1:2k]
//           mode_load_i, mode_i    - per-pair op code load
//           data_out [2*NP-1:0]    - pair k result {hi,lo} at [2k+1:2k]
//           valid_o                - data_out updated this cycle
//           misr_clr_i, misr_o     - signature clear / value
// Revision: 1.0 - initial release
// ============================================================================
module core_logic_pipe
   import core_logic_pkg::*;
#(
   parameter int                NUM_PAIRS = 2,
   parameter int                LATENCY   = 1,
   parameter int                MISR_W    = 16,
   parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021
) (
   input  logic                   TCK,
   input  logic                   TRST_N,
   input  logic                   capture_i,
   input  logic [2*NUM_PAIRS-1:0] data_in,
   input  logic                   mode_load_i,
   input  logic [2*NUM_PAIRS-1:0] mode_i,
   output logic [2*NUM_PAIRS-1:0] data_out,
   output logic                   valid_o,
   input  logic                   misr_clr_i,
   output logic [MISR_W-1:0]      misr_o
);

   localparam int DW = 2 * NUM_PAIRS;

   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("core_logic_pipe: LATENCY must be in 1..4");
   end

   // Shared valid shift register; its last bit is valid_o.
   logic [LATENCY-1:0] r_vld;
   logic               w_out_en;

   always_ff @(posedge TCK or negedge TRST_N) begin
      if (!TRST_N) begin
         r_vld <= '0;
      end else begin
         r_vld[0] <= capture_i;
         for (int i = 1; i < LATENCY; i++) r_vld[i] <= r_vld[i-1];
      end
   end

   // Result registers load in the same edge valid_o rises.
   if (LATENCY == 1) begin : g_en_direct
      assign w_out_en = capture_i;
   end else begin : g_en_piped
      assign w_out_en = r_vld[LATENCY-2];
   end

   assign valid_o = r_vld[LATENCY-1];

   for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_pair
      core_logic_pair #(
         .LATENCY (LATENCY)
      ) u_pair (
         .TCK         (TCK),
         .TRST_N      (TRST_N),
         .mode_load_i (mode_load_i),
         .mode_i      (mode_i[2*k+1:2*k]),
         .a           (data_in[2*k]),
         .b           (data_in[2*k+1]),
         .out_en      (w_out_en),
         .result      (data_out[2*k+1:2*k])
      );
   end

`ifdef CORE_LOGIC_MISR_EN
   logic [MISR_W-1:0] r_misr;
   logic [MISR_W-1:0] w_fold;

   // Wider outputs are XOR-folded into MISR_W bits; narrower ones zero-extend.
   always_comb begin
      w_fold = '0;
      for (int c = 0; c < DW; c += MISR_W) begin
         w_fold = w_fold ^ MISR_W'(data_out >> c);
      end
   end

   // Compacts the result present during the valid_o cycle.
   always_ff @(posedge TCK or negedge TRST_N) begin
      if (!TRST_N)         r_misr <= '0;
      else if (misr_clr_i) r_misr <= '0;
      else if (valid_o)
         r_misr <= ({r_misr[MISR_W-2:0], 1'b0} ^ (r_misr[MISR_W-1] ? MISR_POLY : '0)) ^ w_fold;
   end

   assign misr_o = r_misr;
`else
   logic w_unused_misr_clr;
   assign w_unused_misr_clr = misr_clr_i;
   assign misr_o            = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_logic_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_core_logic_pipe
// Purpose : Directed bench for core_logic_pipe. Three instances with
//           LATENCY 1, 2 and 3 share one stimulus; index g holds LATENCY g+1.
// Revision: 1.0 - initial release
// ============================================================================
module tb_core_logic_pipe;

   logic        TCK         = 1'b0;
   logic        TRST_N      = 1'b0;
   logic        capture_i   = 1'b0;
   logic        mode_load_i = 1'b0;
   logic        misr_clr_i  = 1'b0;
   logic [3:0]  data_in     = '0;
   logic [3:0]  mode_i      = '0;
   logic [3:0]  dout [3];
   logic        vld  [3];
   logic [15:0] misr [3];

   int total = 0;
   int bad   = 0;

   always #5 TCK = ~TCK;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      core_logic_pipe #(
         .NUM_PAIRS (2),
         .LATENCY   (g + 1),
         .MISR_W    (16),
         .MISR_POLY (16'h1021)
      ) u_dut (
         .TCK         (TCK),
         .TRST_N      (TRST_N),
         .capture_i   (capture_i),
         .data_in     (data_in),
         .mode_load_i (mode_load_i),
         .mode_i      (mode_i),
         .data_out    (dout[g]),
         .valid_o     (vld[g]),
         .misr_clr_i  (misr_clr_i),
         .misr_o      (misr[g])
      );
   end

   typedef struct {
      logic [3:0] mode;
      logic [3:0] data;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge TCK);
      #1;
   endtask

   // Drives n back-to-back captures and checks every instance each cycle.
   task automatic burst(input int n, input logic [3:0] d [4], input logic ml [4],
                        input logic [3:0] m [4], input logic [3:0] e [4],
                        input logic [3:0] prev, input string tag);
      for (int k = 0; k <= n + 2; k++) begin
         if (k < n) begin
            capture_i   = 1'b1;
            data_in     = d[k];
            mode_load_i = ml[k];
            mode_i      = m[k];
         end else begin
            capture_i   = 1'b0;
            mode_load_i = 1'b0;
         end
         step();
         for (int g = 0; g < 3; g++) begin
            int j;
            j = k - g;
            if (j >= 0 && j < n) begin
               chk($sformatf("%s L%0d k%0d valid", tag, g + 1, k), 16'(vld[g]), 16'd1);
               chk($sformatf("%s L%0d k%0d data", tag, g + 1, k), 16'(dout[g]), 16'(e[j]));
            end else begin
               chk($sformatf("%s L%0d k%0d valid", tag, g + 1, k), 16'(vld[g]), 16'd0);
               chk($sformatf("%s L%0d k%0d hold", tag, g + 1, k), 16'(dout[g]),
                   16'(j < 0 ? prev : e[n-1]));
            end
         end
      end
   endtask

   initial begin
      logic [3:0] d  [4];
      logic       ml [4];
      logic [3:0] m  [4];
      logic [3:0] e  [4];

      // {mode, data, expected}; mode pair1 at [3:2], pair0 at [1:0]
      vecs[0] = '{4'b0000, 4'b1011, 4'b1011};
      vecs[1] = '{4'b1101, 4'b1110, 4'b1001};
      vecs[2] = '{4'b1010, 4'b0011, 4'b1100};
      vecs[3] = '{4'b0110, 4'b0100, 4'b0111};
      vecs[4] = '{4'b1111, 4'b0110, 4'b0101};
      vecs[5] = '{4'b0001, 4'b0000, 4'b0010};
      vecs[6] = '{4'b0000, 4'b0000, 4'b0000};
      vecs[7] = '{4'b1000, 4'b0001, 4'b1110};

      // Reset with random inputs toggling
      TRST_N = 1'b0;
      for (int i = 0; i < 4; i++) begin
         capture_i   = 1'($urandom);
         mode_load_i = 1'($urandom);
         misr_clr_i  = 1'($urandom);
         data_in     = 4'($urandom);
         mode_i      = 4'($urandom);
         step();
      end
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("reset L%0d data", g + 1), 16'(dout[g]), 16'd0);
         chk($sformatf("reset L%0d valid", g + 1), 16'(vld[g]), 16'd0);
         chk($sformatf("reset L%0d misr", g + 1), misr[g], 16'd0);
      end
      capture_i   = 1'b0;
      mode_load_i = 1'b0;
      misr_clr_i  = 1'b0;
      data_in     = '0;
      mode_i      = '0;
      TRST_N      = 1'b1;
      step();

      // Table-driven op checks
      for (int i = 0; i < 8; i++) begin
         mode_i      = vecs[i].mode;
         mode_load_i = 1'b1;
         data_in     = vecs[i].data;
         step();
         mode_load_i = 1'b0;
         capture_i   = 1'b1;
         step();
         capture_i   = 1'b0;
         chk($sformatf("vec%0d L1 valid", i), 16'(vld[0]), 16'd1);
         chk($sformatf("vec%0d L1 data", i), 16'(dout[0]), 16'(vecs[i].exp));
         step();
         chk($sformatf("vec%0d L1 valid drop", i), 16'(vld[0]), 16'd0);
         chk($sformatf("vec%0d L1 hold", i), 16'(dout[0]), 16'(vecs[i].exp));
         chk($sformatf("vec%0d L2 data", i), 16'(dout[1]), 16'(vecs[i].exp));
      end
      step();

      // Back-to-back captures, mode pair1 NAND / pair0 AND-OR
      d  = '{4'b0001, 4'b0011, 4'b0100, 4'b1100};
      ml = '{1'b0, 1'b0, 1'b0, 1'b0};
      m  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
      e  = '{4'b1110, 4'b1111, 4'b0100, 4'b0000};
      burst(4, d, ml, m, e, 4'b1110, "pipe");

      // Same-cycle load uses old mode; loads with captures in flight
      d  = '{4'b1011, 4'b1011, 4'b0011, 4'b0000};
      ml = '{1'b1, 1'b1, 1'b0, 1'b0};
      m  = '{4'b0101, 4'b1111, 4'b0000, 4'b0000};
      e  = '{4'b0111, 4'b0110, 4'b0010, 4'b0000};
      burst(3, d, ml, m, e, 4'b0000, "modeld");

      // Reset one cycle after a capture flushes the pipeline
      data_in   = 4'b1011;
      capture_i = 1'b1;
      step();
      capture_i = 1'b0;
      data_in   = '0;
      TRST_N    = 1'b0;
      #1;
      chk("midrst L2 valid", 16'(vld[1]), 16'd0);
      chk("midrst L2 data", 16'(dout[1]), 16'd0);
      step();
      step();
      TRST_N = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         for (int g = 0; g < 3; g++) begin
            chk($sformatf("postrst k%0d L%0d valid", k, g + 1), 16'(vld[g]), 16'd0);
            chk($sformatf("postrst k%0d L%0d data", k, g + 1), 16'(dout[g]), 16'd0);
         end
      end

      // MISR sequence on the LATENCY=1 instance; modes are AND-OR after reset
      misr_clr_i = 1'b1;
      step();
      misr_clr_i = 1'b0;
      d = '{4'b1011, 4'b0110, 4'b1111, 4'b0000};
      for (int k = 0; k < 3; k++) begin
         capture_i = 1'b1;
         data_in   = d[k];
         step();
      end
      capture_i = 1'b0;
      chk("misr seq last data", 16'(dout[0]), 16'h000F);
      step();
`ifdef CORE_LOGIC_MISR_EN
      chk("misr after 3", misr[0], 16'h0037);
`else
      chk("misr tied L1", misr[0], 16'h0000);
`endif
      capture_i = 1'b1;
      data_in   = 4'b0001;
      step();
      capture_i  = 1'b0;
      misr_clr_i = 1'b1;
      chk("misr clr cycle valid", 16'(vld[0]), 16'd1);
`ifdef CORE_LOGIC_MISR_EN
      chk("misr idle hold", misr[0], 16'h0037);
`else
      chk("misr tied L1 b", misr[0], 16'h0000);
`endif
      step();
      misr_clr_i = 1'b0;
      chk("misr clr priority", misr[0], 16'h0000);
      step();
      step();
`ifndef CORE_LOGIC_MISR_EN
      chk("misr tied L2", misr[1], 16'h0000);
      chk("misr tied L3", misr[2], 16'h0000);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
